// File: rtl/uart_pkg.sv
// Shared definitions for the UART Rx packet controller: FSM states, status codes
// and the bit positions of the frame-format word.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    typedef logic [2:0] err_code_t;

    localparam err_code_t ERR_OK       = 3'd0;
    localparam err_code_t ERR_CHECKSUM = 3'd1;
    localparam err_code_t ERR_PARITY   = 3'd2;
    localparam err_code_t ERR_FRAMING  = 3'd3;
    localparam err_code_t ERR_TIMEOUT  = 3'd4;
    localparam err_code_t ERR_LENGTH   = 3'd5;

    localparam int MODE_SEVEN_BIT  = 0;
    localparam int MODE_PARITY_EN  = 1;
    localparam int MODE_ODD_PARITY = 2;
    localparam int MODE_STOP_BIT   = 3;

endpackage

// File: rtl/uart_rx_packet_ctrl_if.sv
// Byte stream from the UART Rx core in, framed payload stream and packet status out.
interface uart_rx_packet_ctrl_if;
    import uart_pkg::*;

    logic       iRX_DE;
    logic [7:0] iRX_DATA;
    logic       iRX_RETRY;
    logic       iRX_PARITY_ERROR;

    logic       oPKT_VALID;
    logic [7:0] oPKT_DATA;
    logic       oPKT_LAST;
    logic       oPKT_DONE;
    err_code_t  oPKT_ERR;

    modport master (
        input  iRX_DE, iRX_DATA, iRX_RETRY, iRX_PARITY_ERROR,
        output oPKT_VALID, oPKT_DATA, oPKT_LAST, oPKT_DONE, oPKT_ERR
    );

    modport slave (
        output iRX_DE, iRX_DATA, iRX_RETRY, iRX_PARITY_ERROR,
        input  oPKT_VALID, oPKT_DATA, oPKT_LAST, oPKT_DONE, oPKT_ERR
    );

endinterface

// File: rtl/uart_ce_gen.sv
// Oversampling clock-enable generator: one-cycle pulse every DIV+1 clocks,
// restartable from zero when a new divider is applied.
module uart_ce_gen (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] iDIV,
    input  logic        iRESTART,
    output logic        oCLK_CE
);

    logic [15:0] presc_q, presc_d;

    always_comb begin
        presc_d = presc_q + 16'd1;
        if (iRESTART || (presc_q == iDIV)) presc_d = '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) presc_q <= '0;
        else     presc_q <= presc_d;
    end

    // DIV = 0 keeps the prescaler at zero, so the enable stays high.
    assign oCLK_CE = (presc_q == iDIV);

endmodule

// File: rtl/uart_rx_packet_ctrl.sv
// UART Rx sequencer: drives the core's CE and frame format, then frames received
// bytes as SYNC, LEN, payload, CHK and streams the payload with per-packet status.
module uart_rx_packet_ctrl
    import uart_pkg::*;
#(
    parameter logic [15:0] DEFAULT_DIV   = 16'd26,
    parameter logic [3:0]  DEFAULT_MODE  = 4'b0000,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
    parameter int          MAX_LEN       = 16,
    parameter int          TIMEOUT_TICKS = 400
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  iCFG_WE,
    input  logic [15:0]           iCFG_DIV,
    input  logic [3:0]            iCFG_MODE,
    output logic                  oCLK_CE,
    output logic                  oSEVEN_BIT,
    output logic                  oPARITY_EN,
    output logic                  oODD_PARITY,
    output logic                  oSTOP_BIT,
    uart_rx_packet_ctrl_if.master bus,
    output logic [7:0]            oERR_COUNT,
    output logic                  oBUSY
);

    localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);

    state_e          state_q, state_d;
    err_code_t       err_q, err_d;
    logic [15:0]     div_q, div_d, pend_div_q, pend_div_d;
    logic [3:0]      mode_q, mode_d, pend_mode_q, pend_mode_d;
    logic            pend_q, pend_d;
    logic            rx_de_q, rx_de_d, rx_retry_q, rx_retry_d;
    logic [7:0]      rem_q, rem_d, sum_q, sum_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            pkt_valid_q, pkt_valid_d, pkt_last_q, pkt_last_d;
    logic [7:0]      pkt_data_q, pkt_data_d;
    logic [7:0]      err_cnt_q, err_cnt_d;

    logic            byte_ev, err_ev, byte_ok, in_pkt, timeout_hit, cfg_apply, ce;
    logic [7:0]      chk_sum;

    uart_ce_gen u_ce_gen (
        .CLK      (CLK),
        .RST      (RST),
        .iDIV     (div_q),
        .iRESTART (cfg_apply),
        .oCLK_CE  (ce)
    );

    // Core outputs are held for a full CE period, so events are edges of the held levels.
    always_comb begin
        rx_de_d     = bus.iRX_DE;
        rx_retry_d  = bus.iRX_RETRY;
        byte_ev     = bus.iRX_DE & ~rx_de_q;
        err_ev      = bus.iRX_RETRY & ~rx_retry_q;
        byte_ok     = byte_ev & ~err_ev;
        in_pkt      = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
        timeout_hit = in_pkt && !byte_ev && ce && (to_cnt_q == TO_W'(TIMEOUT_TICKS - 1));
        cfg_apply   = pend_q && (state_q == ST_HUNT) && !byte_ev;
        chk_sum     = sum_q + bus.iRX_DATA;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_HUNT;
            err_q       <= ERR_OK;
            div_q       <= DEFAULT_DIV;
            mode_q      <= DEFAULT_MODE;
            pend_div_q  <= '0;
            pend_mode_q <= '0;
            pend_q      <= 1'b0;
            rx_de_q     <= 1'b0;
            rx_retry_q  <= 1'b0;
            rem_q       <= '0;
            sum_q       <= '0;
            to_cnt_q    <= '0;
            pkt_valid_q <= 1'b0;
            pkt_last_q  <= 1'b0;
            pkt_data_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            div_q       <= div_d;
            mode_q      <= mode_d;
            pend_div_q  <= pend_div_d;
            pend_mode_q <= pend_mode_d;
            pend_q      <= pend_d;
            rx_de_q     <= rx_de_d;
            rx_retry_q  <= rx_retry_d;
            rem_q       <= rem_d;
            sum_q       <= sum_d;
            to_cnt_q    <= to_cnt_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_last_q  <= pkt_last_d;
            pkt_data_q  <= pkt_data_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        rem_d       = rem_q;
        sum_d       = sum_q;
        div_d       = div_q;
        mode_d      = mode_q;
        pend_d      = pend_q;
        pend_div_d  = pend_div_q;
        pend_mode_d = pend_mode_q;
        to_cnt_d    = to_cnt_q;

        if (!in_pkt || byte_ev) to_cnt_d = '0;
        else if (ce)            to_cnt_d = to_cnt_q + TO_W'(1);

        if (cfg_apply) begin
            div_d  = pend_div_q;
            mode_d = pend_mode_q;
            pend_d = 1'b0;
        end
        // A write landing on the apply cycle stays pending for the next one.
        if (iCFG_WE) begin
            pend_d      = 1'b1;
            pend_div_d  = iCFG_DIV;
            pend_mode_d = iCFG_MODE;
        end

        case (state_q)
            ST_HUNT: begin
                if (byte_ok && (bus.iRX_DATA == SYNC_BYTE)) begin
                    state_d = ST_LEN;
                    err_d   = ERR_OK;
                end
            end
            ST_LEN, ST_PAYLOAD, ST_CHK: begin
                if (err_ev) begin
                    state_d = ST_DONE;
                    err_d   = bus.iRX_PARITY_ERROR ? ERR_PARITY : ERR_FRAMING;
                end else if (byte_ev) begin
                    if (state_q == ST_LEN) begin
                        if ((bus.iRX_DATA == 8'd0) || (int'(bus.iRX_DATA) > MAX_LEN)) begin
                            state_d = ST_DONE;
                            err_d   = ERR_LENGTH;
                        end else begin
                            state_d = ST_PAYLOAD;
                            rem_d   = bus.iRX_DATA;
                            sum_d   = bus.iRX_DATA;
                        end
                    end else if (state_q == ST_PAYLOAD) begin
                        sum_d = chk_sum;
                        rem_d = rem_q - 8'd1;
                        if (rem_q == 8'd1) state_d = ST_CHK;
                    end else begin
                        state_d = ST_DONE;
                        err_d   = (chk_sum == 8'd0) ? ERR_OK : ERR_CHECKSUM;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_DONE;
                    err_d   = ERR_TIMEOUT;
                end
            end
            ST_DONE: state_d = ST_HUNT;
            default: state_d = ST_HUNT;
        endcase
    end

    always_comb begin
        pkt_valid_d = 1'b0;
        pkt_last_d  = 1'b0;
        pkt_data_d  = pkt_data_q;
        err_cnt_d   = err_cnt_q;
        if ((state_q == ST_PAYLOAD) && byte_ok) begin
            pkt_valid_d = 1'b1;
            pkt_data_d  = bus.iRX_DATA;
            pkt_last_d  = (rem_q == 8'd1);
        end
        if ((state_q == ST_DONE) && (err_q != ERR_OK) && (err_cnt_q != 8'hFF))
            err_cnt_d = err_cnt_q + 8'd1;
    end

    assign oCLK_CE        = ce;
    assign oSEVEN_BIT     = mode_q[MODE_SEVEN_BIT];
    assign oPARITY_EN     = mode_q[MODE_PARITY_EN];
    assign oODD_PARITY    = mode_q[MODE_ODD_PARITY];
    assign oSTOP_BIT      = mode_q[MODE_STOP_BIT];
    assign bus.oPKT_VALID = pkt_valid_q;
    assign bus.oPKT_DATA  = pkt_data_q;
    assign bus.oPKT_LAST  = pkt_last_q;
    assign bus.oPKT_DONE  = (state_q == ST_DONE);
    assign bus.oPKT_ERR   = (state_q == ST_DONE) ? err_q : ERR_OK;
    assign oERR_COUNT     = err_cnt_q;
    assign oBUSY          = (state_q != ST_HUNT);

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// Bench for uart_rx_packet_ctrl: directed and randomized packets against a
// packet-level reference model.
module tb_uart_rx_packet_ctrl;
    import uart_pkg::*;

    localparam logic [15:0] T_DIV  = 16'd3;
    localparam logic [3:0]  T_MODE = 4'b0101;
    localparam int          T_MAX  = 16;
    localparam int          T_TO   = 400;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iCFG_WE;
    logic [15:0] iCFG_DIV;
    logic [3:0]  iCFG_MODE;
    logic        oCLK_CE, oSEVEN_BIT, oPARITY_EN, oODD_PARITY, oSTOP_BIT;
    logic [7:0]  oERR_COUNT;
    logic        oBUSY;

    uart_rx_packet_ctrl_if bus();

    uart_rx_packet_ctrl #(
        .DEFAULT_DIV  (T_DIV),
        .DEFAULT_MODE (T_MODE),
        .SYNC_BYTE    (8'hA5),
        .MAX_LEN      (T_MAX),
        .TIMEOUT_TICKS(T_TO)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .iCFG_WE    (iCFG_WE),
        .iCFG_DIV   (iCFG_DIV),
        .iCFG_MODE  (iCFG_MODE),
        .oCLK_CE    (oCLK_CE),
        .oSEVEN_BIT (oSEVEN_BIT),
        .oPARITY_EN (oPARITY_EN),
        .oODD_PARITY(oODD_PARITY),
        .oSTOP_BIT  (oSTOP_BIT),
        .bus        (bus),
        .oERR_COUNT (oERR_COUNT),
        .oBUSY      (oBUSY)
    );

    always #5 CLK = ~CLK;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          exp_err_count = 0;
    logic [3:0]  cur_mode = T_MODE;

    logic [7:0]  got_data[$];
    bit          got_last[$];
    logic [2:0]  got_err[$];

    logic [7:0]  seq[$];
    logic [7:0]  exp_data[$];
    bit          exp_last[$];
    logic [2:0]  exp_err;

    always @(negedge CLK) begin
        if (bus.oPKT_VALID) begin
            got_data.push_back(bus.oPKT_DATA);
            got_last.push_back(bus.oPKT_LAST);
        end
        if (bus.oPKT_DONE) got_err.push_back(bus.oPKT_ERR);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic load_seq(input int n, input logic [63:0] v);
        seq.delete();
        for (int i = n - 1; i >= 0; i--) seq.push_back(v[i*8 +: 8]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.iRX_DATA = b;
        bus.iRX_DE   = 1'b1;
        tick(2);
        bus.iRX_DE   = 1'b0;
        tick(2);
    endtask

    task automatic pulse_retry(input logic pe, input logic with_byte, input logic [7:0] b);
        bus.iRX_PARITY_ERROR = pe;
        bus.iRX_RETRY        = 1'b1;
        if (with_byte) begin
            bus.iRX_DATA = b;
            bus.iRX_DE   = 1'b1;
        end
        tick(2);
        bus.iRX_RETRY = 1'b0;
        bus.iRX_DE    = 1'b0;
        tick(2);
    endtask

    task automatic cfg_write(input logic [15:0] div, input logic [3:0] mode);
        iCFG_WE   = 1'b1;
        iCFG_DIV  = div;
        iCFG_MODE = mode;
        tick(1);
        iCFG_WE   = 1'b0;
    endtask

    // Whole-packet reference: locate SYNC, validate LEN, sum bytes, test the checksum.
    task automatic model_packet();
        int i, len, sum;
        exp_data.delete();
        exp_last.delete();
        i = 0;
        while (i < seq.size() && seq[i] != 8'hA5) i++;
        len = int'(seq[i+1]);
        if (len == 0 || len > T_MAX) begin
            exp_err = ERR_LENGTH;
            return;
        end
        sum = len;
        for (int k = 0; k < len; k++) begin
            exp_data.push_back(seq[i+2+k]);
            exp_last.push_back(k == len - 1);
            sum += int'(seq[i+2+k]);
        end
        sum += int'(seq[i+2+len]);
        exp_err = (sum % 256 == 0) ? ERR_OK : ERR_CHECKSUM;
    endtask

    // Payload bytes sent after SYNC,LEN before an abort, none flagged last.
    task automatic model_prefix();
        exp_data.delete();
        exp_last.delete();
        for (int k = 2; k < seq.size(); k++) begin
            exp_data.push_back(seq[k]);
            exp_last.push_back(1'b0);
        end
    endtask

    task automatic wait_done(input int e0, input int budget);
        for (int c = 0; c < budget && got_err.size() == e0; c++) tick(1);
    endtask

    task automatic finish_check(input string name, input int d0, input int e0);
        tests_run++;
        if (got_err.size() != e0 + 1) begin
            tests_failed++;
            $display("FAIL %s done_count: got %0d required 1", name, got_err.size() - e0);
        end else begin
            tests_run++;
            if (got_err[e0] !== exp_err) begin
                tests_failed++;
                $display("FAIL %s err: got %0d required %0d", name, got_err[e0], exp_err);
            end
        end
        tests_run++;
        if (got_data.size() - d0 != exp_data.size()) begin
            tests_failed++;
            $display("FAIL %s payload_len: got %0d required %0d", name, got_data.size() - d0, exp_data.size());
        end else begin
            for (int i = 0; i < exp_data.size(); i++) begin
                tests_run++;
                if (got_data[d0+i] !== exp_data[i] || got_last[d0+i] !== exp_last[i]) begin
                    tests_failed++;
                    $display("FAIL %s byte%0d: got %h/%0d required %h/%0d", name, i,
                             got_data[d0+i], got_last[d0+i], exp_data[i], exp_last[i]);
                end
            end
        end
        if (exp_err != ERR_OK && exp_err_count < 255) exp_err_count++;
        tick(2);
        tests_run++;
        if (oERR_COUNT !== 8'(exp_err_count) || oBUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s err_count/busy: got %0d/%0d required %0d/0", name, oERR_COUNT, oBUSY, exp_err_count);
        end
    endtask

    task automatic run_and_check(input string name);
        int d0, e0;
        d0 = got_data.size();
        e0 = got_err.size();
        model_packet();
        foreach (seq[i]) send_byte(seq[i]);
        wait_done(e0, 40);
        finish_check(name, d0, e0);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        iCFG_WE = 1'b0; iCFG_DIV = '0; iCFG_MODE = '0;
        bus.iRX_DE = 1'b0; bus.iRX_DATA = '0; bus.iRX_RETRY = 1'b0; bus.iRX_PARITY_ERROR = 1'b0;
        tick(3);
        tests_run++;
        if ({oSTOP_BIT, oODD_PARITY, oPARITY_EN, oSEVEN_BIT} !== T_MODE) begin
            tests_failed++;
            $display("FAIL reset_mode: got %b required %b", {oSTOP_BIT, oODD_PARITY, oPARITY_EN, oSEVEN_BIT}, T_MODE);
        end
        tests_run++;
        if ({oCLK_CE, bus.oPKT_VALID, bus.oPKT_LAST, bus.oPKT_DONE, bus.oPKT_ERR, oERR_COUNT, oBUSY, bus.oPKT_DATA} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: ce=%0d valid=%0d last=%0d done=%0d err=%0d cnt=%0d busy=%0d data=%h required all 0",
                     oCLK_CE, bus.oPKT_VALID, bus.oPKT_LAST, bus.oPKT_DONE, bus.oPKT_ERR, oERR_COUNT, oBUSY, bus.oPKT_DATA);
        end
        RST = 1'b0;
    endtask

    task automatic test_ce();
        int first;
        first = -1;
        for (int c = 0; c < 8 && first < 0; c++) begin
            tick(1);
            if (oCLK_CE === 1'b1) first = c;
        end
        tests_run++;
        if (first < 0) begin
            tests_failed++;
            $display("FAIL ce_first: got none required a pulse within 4 cycles");
        end
        for (int c = 1; c <= 16; c++) begin
            tick(1);
            tests_run++;
            if (oCLK_CE !== 1'((c % 4) == 0)) begin
                tests_failed++;
                $display("FAIL ce_div3 cycle%0d: got %0d required %0d", c, oCLK_CE, (c % 4) == 0);
            end
        end
        cfg_write(16'd0, cur_mode);
        for (int c = 0; c < 8; c++) begin
            tick(1);
            tests_run++;
            if (oCLK_CE !== 1'b1) begin
                tests_failed++;
                $display("FAIL ce_div0 cycle%0d: got %0d required 1", c, oCLK_CE);
            end
        end
        cfg_write(T_DIV, cur_mode);
        tick(2);
    endtask

    task automatic test_packets();
        load_seq(5, 64'hA5_02_11_22_CB);
        run_and_check("pkt_ok");
        load_seq(5, 64'hA5_02_11_22_00);
        run_and_check("pkt_checksum");
        load_seq(2, 64'hA5_00);
        run_and_check("len_zero");
        load_seq(2, 64'hA5_11);
        run_and_check("len_17");
        seq.delete();
        seq.push_back(8'hA5);
        seq.push_back(8'd16);
        for (int i = 0; i < 16; i++) seq.push_back(8'(i * 7 + 3));
        seq.push_back(8'h00);
        run_and_check("len_max");
    endtask

    task automatic test_abort(input string name, input logic pe, input logic with_byte);
        int d0, e0;
        d0 = got_data.size();
        e0 = got_err.size();
        model_prefix();
        exp_err = pe ? ERR_PARITY : ERR_FRAMING;
        foreach (seq[i]) send_byte(seq[i]);
        pulse_retry(pe, with_byte, 8'h44);
        wait_done(e0, 40);
        finish_check(name, d0, e0);
    endtask

    task automatic test_timeout();
        int d0, e0, ticks;
        d0 = got_data.size();
        e0 = got_err.size();
        load_seq(3, 64'hA5_02_11);
        model_prefix();
        exp_err = ERR_TIMEOUT;
        foreach (seq[i]) send_byte(seq[i]);
        ticks = 0;
        for (int c = 0; c < 2200 && got_err.size() == e0; c++) begin
            tick(1);
            if (oCLK_CE === 1'b1 && got_err.size() == e0) ticks++;
        end
        tests_run++;
        if (ticks < 396 || ticks > 401) begin
            tests_failed++;
            $display("FAIL timeout_ticks: got %0d required about %0d", ticks, T_TO);
        end
        finish_check("timeout", d0, e0);
    endtask

    task automatic test_cfg_mid_packet();
        int d0, e0;
        logic [3:0] new_mode;
        new_mode = ~cur_mode;
        d0 = got_data.size();
        e0 = got_err.size();
        load_seq(5, 64'hA5_02_11_22_CB);
        model_packet();
        send_byte(seq[0]);
        send_byte(seq[1]);
        cfg_write(T_DIV, new_mode);
        tick(4);
        tests_run++;
        if ({oSTOP_BIT, oODD_PARITY, oPARITY_EN, oSEVEN_BIT} !== cur_mode) begin
            tests_failed++;
            $display("FAIL cfg_hold: got %b required %b", {oSTOP_BIT, oODD_PARITY, oPARITY_EN, oSEVEN_BIT}, cur_mode);
        end
        for (int i = 2; i < 5; i++) send_byte(seq[i]);
        wait_done(e0, 40);
        finish_check("cfg_mid", d0, e0);
        tick(2);
        cur_mode = new_mode;
        tests_run++;
        if ({oSTOP_BIT, oODD_PARITY, oPARITY_EN, oSEVEN_BIT} !== cur_mode) begin
            tests_failed++;
            $display("FAIL cfg_apply: got %b required %b", {oSTOP_BIT, oODD_PARITY, oPARITY_EN, oSEVEN_BIT}, cur_mode);
        end
    endtask

    task automatic test_random();
        int len, sum, sel;
        logic [7:0] b;
        for (int n = 0; n < 30; n++) begin
            seq.delete();
            for (int k = $urandom_range(0, 3); k > 0; k--) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h5A;
                seq.push_back(b);
            end
            if ($urandom_range(0, 3) == 0) pulse_retry(1'($urandom), 1'b0, 8'h00);
            seq.push_back(8'hA5);
            sel = $urandom_range(0, 9);
            if (sel == 0)      len = 0;
            else if (sel == 1) len = $urandom_range(T_MAX + 1, 255);
            else               len = $urandom_range(1, T_MAX);
            seq.push_back(8'(len));
            if (len >= 1 && len <= T_MAX) begin
                sum = len;
                for (int k = 0; k < len; k++) begin
                    b = 8'($urandom);
                    seq.push_back(b);
                    sum += int'(b);
                end
                b = 8'((256 - (sum % 256)) % 256);
                if ($urandom_range(0, 3) == 0) b = b ^ 8'($urandom_range(1, 255));
                seq.push_back(b);
            end
            run_and_check("random");
        end
    endtask

    task automatic test_reset_mid_packet();
        int e0;
        e0 = got_err.size();
        load_seq(3, 64'hA5_02_11);
        foreach (seq[i]) send_byte(seq[i]);
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        tick(4);
        exp_err_count = 0;
        cur_mode = T_MODE;
        tests_run++;
        if (got_err.size() != e0 || oBUSY !== 1'b0 || oERR_COUNT !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_mid: got done=%0d busy=%0d cnt=%0d required 0/0/0", got_err.size() - e0, oBUSY, oERR_COUNT);
        end
        tests_run++;
        if ({oSTOP_BIT, oODD_PARITY, oPARITY_EN, oSEVEN_BIT} !== T_MODE) begin
            tests_failed++;
            $display("FAIL reset_mid_mode: got %b required %b", {oSTOP_BIT, oODD_PARITY, oPARITY_EN, oSEVEN_BIT}, T_MODE);
        end
    endtask

    task automatic test_saturation();
        int e0;
        e0 = got_err.size();
        for (int i = 0; i < 258; i++) begin
            send_byte(8'hA5);
            send_byte(8'h00);
            tick(3);
            if (exp_err_count < 255) exp_err_count++;
        end
        tests_run++;
        if (got_err.size() - e0 != 258) begin
            tests_failed++;
            $display("FAIL sat_done_count: got %0d required 258", got_err.size() - e0);
        end
        tests_run++;
        if (oERR_COUNT !== 8'(exp_err_count)) begin
            tests_failed++;
            $display("FAIL sat_count: got %0d required %0d", oERR_COUNT, exp_err_count);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ce();
        test_packets();
        load_seq(3, 64'hA5_03_01);
        test_abort("abort_parity", 1'b1, 1'b0);
        load_seq(3, 64'hA5_03_01);
        test_abort("abort_framing", 1'b0, 1'b0);
        load_seq(2, 64'hA5_03);
        test_abort("abort_simultaneous", 1'b1, 1'b1);
        test_timeout();
        test_cfg_mid_packet();
        test_random();
        test_reset_mid_packet();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
